// File: rtl/rv32f_pkg.sv
// rtl/rv32f_pkg.sv - shared constants and helpers for the RV32F register file
package rv32f_pkg;

   localparam int REG_IDX_W  = 5;
   localparam int CSR_ADDR_W = 12;
   localparam int FFLAGS_W   = 5;
   localparam int FRM_W      = 3;

   // CSR addresses
   localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_FFLAGS = 12'h001;
   localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_FRM    = 12'h002;
   localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_FCSR   = 12'h003;

   // CSR op encodings
   typedef enum logic [1:0] {
      CSR_OP_READ  = 2'b00,
      CSR_OP_WRITE = 2'b01,
      CSR_OP_SET   = 2'b10,
      CSR_OP_CLEAR = 2'b11
   } csr_op_e;

   // fflags bit positions: {NV,DZ,OF,UF,NX}
   localparam int FFLAG_NX = 0;
   localparam int FFLAG_UF = 1;
   localparam int FFLAG_OF = 2;
   localparam int FFLAG_DZ = 3;
   localparam int FFLAG_NV = 4;

   // Reserved rounding-mode encodings
   localparam logic [FRM_W-1:0] FRM_RSVD_5 = 3'd5;
   localparam logic [FRM_W-1:0] FRM_RSVD_6 = 3'd6;
   localparam logic [FRM_W-1:0] FRM_RSVD_7 = 3'd7;

   function automatic logic frm_is_reserved(input logic [FRM_W-1:0] frm);
      return (frm == FRM_RSVD_5) || (frm == FRM_RSVD_6) || (frm == FRM_RSVD_7);
   endfunction

   // Read-modify-write of an 8-bit CSR image; callers keep only the field bits they own
   function automatic logic [7:0] csr_apply(input logic [1:0] op,
                                            input logic [7:0] old_v,
                                            input logic [7:0] wdata);
      logic [7:0] res;
      case (csr_op_e'(op))
         CSR_OP_WRITE: res = wdata;
         CSR_OP_SET:   res = old_v | wdata;
         CSR_OP_CLEAR: res = old_v & ~wdata;
         default:      res = old_v;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/rv32f_scoreboard.sv
// rtl/rv32f_scoreboard.sv - busy-bit scoreboard and issue stall for FP registers
module rv32f_scoreboard
   import rv32f_pkg::*;
#(
   parameter int NREG = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] rs1,
   input  logic [REG_IDX_W-1:0] rs2,
   input  logic [REG_IDX_W-1:0] rs3,
   input  logic                 use_rs1,
   input  logic                 use_rs2,
   input  logic                 use_rs3,
   input  logic                 issue_en,
   input  logic [REG_IDX_W-1:0] issue_rd,
   input  logic                 wr_en,
   input  logic [REG_IDX_W-1:0] wr_addr,
   output logic                 stall
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic            raw1, raw2, raw3, waw;

   // Hazard detection; a same-cycle writeback resolves the hazard on its register
   always_comb begin
      raw1  = use_rs1 && busy_q[rs1] && !(wr_en && (wr_addr == rs1));
      raw2  = use_rs2 && busy_q[rs2] && !(wr_en && (wr_addr == rs2));
      raw3  = use_rs3 && busy_q[rs3] && !(wr_en && (wr_addr == rs3));
      waw   = issue_en && busy_q[issue_rd] && !(wr_en && (wr_addr == issue_rd));
      stall = raw1 || raw2 || raw3 || waw;
   end

   // Busy update: writeback clears, then a non-stalled issue sets (set wins)
   always_comb begin
      busy_d = busy_q;
      if (wr_en) begin
         busy_d[wr_addr] = 1'b0;
      end
      if (issue_en && !stall) begin
         busy_d[issue_rd] = 1'b1;
      end
   end

   // Busy vector register
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/rv32f_fpr_file.sv
// rtl/rv32f_fpr_file.sv - RV32F register file with fcsr and issue scoreboard
module rv32f_fpr_file
   import rv32f_pkg::*;
#(
   parameter int NREG = 32,
   parameter int FLEN = 32
) (
   input  logic                  iCLK,
   input  logic                  iRST,
   input  logic [REG_IDX_W-1:0]  iRS1,
   input  logic [REG_IDX_W-1:0]  iRS2,
   input  logic [REG_IDX_W-1:0]  iRS3,
   output logic [FLEN-1:0]       oRS1_DATA,
   output logic [FLEN-1:0]       oRS2_DATA,
   output logic [FLEN-1:0]       oRS3_DATA,
   input  logic                  iUSE_RS1,
   input  logic                  iUSE_RS2,
   input  logic                  iUSE_RS3,
   input  logic                  iISSUE_EN,
   input  logic [REG_IDX_W-1:0]  iISSUE_RD,
   input  logic                  iWR_EN,
   input  logic [REG_IDX_W-1:0]  iWR_ADDR,
   input  logic [FLEN-1:0]       iWR_DATA,
   input  logic [FFLAGS_W-1:0]   iWR_FLAGS,
   input  logic                  iCSR_EN,
   input  logic [1:0]            iCSR_OP,
   input  logic [CSR_ADDR_W-1:0] iCSR_ADDR,
   input  logic [31:0]           iCSR_WDATA,
   output logic [31:0]           oCSR_RDATA,
   output logic                  oCSR_ILLEGAL,
   output logic [FRM_W-1:0]      oFRM,
   output logic                  oFRM_INVALID,
   output logic                  oSTALL
);

   logic [FLEN-1:0]     regs_q [NREG];
   logic [FLEN-1:0]     regs_d [NREG];
   logic [FRM_W-1:0]    frm_q, frm_d;
   logic [FFLAGS_W-1:0] fflags_q, fflags_d;

   logic       csr_legal;
   logic       csr_upd;
   logic [7:0] csr_old;
   logic [7:0] csr_new;
   logic       unused_csr_wdata_hi;

   assign unused_csr_wdata_hi = ^iCSR_WDATA[31:8];

   // Combinational reads with write-through bypass from the writeback port
   always_comb begin
      oRS1_DATA = (iWR_EN && (iWR_ADDR == iRS1)) ? iWR_DATA : regs_q[iRS1];
      oRS2_DATA = (iWR_EN && (iWR_ADDR == iRS2)) ? iWR_DATA : regs_q[iRS2];
      oRS3_DATA = (iWR_EN && (iWR_ADDR == iRS3)) ? iWR_DATA : regs_q[iRS3];
   end

   // Register array next state; f0 is an ordinary register
   always_comb begin
      regs_d = regs_q;
      if (iWR_EN) begin
         regs_d[iWR_ADDR] = iWR_DATA;
      end
   end

   // CSR decode and read mux; reads return the pre-update image
   always_comb begin
      csr_legal = (iCSR_ADDR == CSR_ADDR_FFLAGS) ||
                  (iCSR_ADDR == CSR_ADDR_FRM)    ||
                  (iCSR_ADDR == CSR_ADDR_FCSR);
      case (iCSR_ADDR)
         CSR_ADDR_FFLAGS: csr_old = {3'b000, fflags_q};
         CSR_ADDR_FRM:    csr_old = {5'b00000, frm_q};
         CSR_ADDR_FCSR:   csr_old = {frm_q, fflags_q};
         default:         csr_old = 8'h00;
      endcase
      csr_new      = csr_apply(iCSR_OP, csr_old, iCSR_WDATA[7:0]);
      csr_upd      = iCSR_EN && csr_legal && (csr_op_e'(iCSR_OP) != CSR_OP_READ);
      oCSR_RDATA   = (iCSR_EN && csr_legal) ? {24'h000000, csr_old} : 32'h0;
      oCSR_ILLEGAL = iCSR_EN && !csr_legal;
   end

   // fcsr next state; writeback flags are ORed on top of any CSR result
   always_comb begin
      frm_d    = frm_q;
      fflags_d = fflags_q;
      if (csr_upd) begin
         case (iCSR_ADDR)
            CSR_ADDR_FFLAGS: fflags_d = csr_new[FFLAGS_W-1:0];
            CSR_ADDR_FRM:    frm_d    = csr_new[FRM_W-1:0];
            CSR_ADDR_FCSR: begin
               frm_d    = csr_new[7:5];
               fflags_d = csr_new[FFLAGS_W-1:0];
            end
            default: ;
         endcase
      end
      if (iWR_EN) begin
         fflags_d = fflags_d | iWR_FLAGS;
      end
   end

   // Rounding mode is the stored value only; a same-cycle CSR write shows next cycle
   always_comb begin
      oFRM         = frm_q;
      oFRM_INVALID = frm_is_reserved(frm_q);
   end

   // State registers; reset discards everything presented in the same cycle
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         frm_q    <= '0;
         fflags_q <= '0;
      end else begin
         regs_q   <= regs_d;
         frm_q    <= frm_d;
         fflags_q <= fflags_d;
      end
   end

   rv32f_scoreboard #(
      .NREG (NREG)
   ) u_scoreboard (
      .clk      (iCLK),
      .rst      (iRST),
      .rs1      (iRS1),
      .rs2      (iRS2),
      .rs3      (iRS3),
      .use_rs1  (iUSE_RS1),
      .use_rs2  (iUSE_RS2),
      .use_rs3  (iUSE_RS3),
      .issue_en (iISSUE_EN),
      .issue_rd (iISSUE_RD),
      .wr_en    (iWR_EN),
      .wr_addr  (iWR_ADDR),
      .stall    (oSTALL)
   );

endmodule

// File: tb/tb_rv32f_fpr_file.sv
// tb/tb_rv32f_fpr_file.sv - randomized self-checking bench for rv32f_fpr_file
module tb_rv32f_fpr_file;

   logic        iCLK = 1'b0;
   logic        iRST;
   logic [4:0]  iRS1, iRS2, iRS3;
   logic [31:0] oRS1_DATA, oRS2_DATA, oRS3_DATA;
   logic        iUSE_RS1, iUSE_RS2, iUSE_RS3;
   logic        iISSUE_EN;
   logic [4:0]  iISSUE_RD;
   logic        iWR_EN;
   logic [4:0]  iWR_ADDR;
   logic [31:0] iWR_DATA;
   logic [4:0]  iWR_FLAGS;
   logic        iCSR_EN;
   logic [1:0]  iCSR_OP;
   logic [11:0] iCSR_ADDR;
   logic [31:0] iCSR_WDATA;
   logic [31:0] oCSR_RDATA;
   logic        oCSR_ILLEGAL;
   logic [2:0]  oFRM;
   logic        oFRM_INVALID;
   logic        oSTALL;

   int n_vec = 0;
   int n_bad = 0;

   // reference model state
   logic [31:0] m_regs [32];
   bit          m_busy [32];
   int          m_frm;
   int          m_fflags;

   always #5 iCLK = ~iCLK;

   rv32f_fpr_file #(.NREG(32), .FLEN(32)) dut (
      .iCLK(iCLK), .iRST(iRST),
      .iRS1(iRS1), .iRS2(iRS2), .iRS3(iRS3),
      .oRS1_DATA(oRS1_DATA), .oRS2_DATA(oRS2_DATA), .oRS3_DATA(oRS3_DATA),
      .iUSE_RS1(iUSE_RS1), .iUSE_RS2(iUSE_RS2), .iUSE_RS3(iUSE_RS3),
      .iISSUE_EN(iISSUE_EN), .iISSUE_RD(iISSUE_RD),
      .iWR_EN(iWR_EN), .iWR_ADDR(iWR_ADDR), .iWR_DATA(iWR_DATA), .iWR_FLAGS(iWR_FLAGS),
      .iCSR_EN(iCSR_EN), .iCSR_OP(iCSR_OP), .iCSR_ADDR(iCSR_ADDR), .iCSR_WDATA(iCSR_WDATA),
      .oCSR_RDATA(oCSR_RDATA), .oCSR_ILLEGAL(oCSR_ILLEGAL),
      .oFRM(oFRM), .oFRM_INVALID(oFRM_INVALID), .oSTALL(oSTALL)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] idx);
      if (iWR_EN && iWR_ADDR == idx) return iWR_DATA;
      return m_regs[idx];
   endfunction

   function automatic bit m_blocked(input logic [4:0] idx);
      return m_busy[idx] && !(iWR_EN && iWR_ADDR == idx);
   endfunction

   function automatic bit m_stall();
      return (iUSE_RS1 && m_blocked(iRS1)) || (iUSE_RS2 && m_blocked(iRS2)) ||
             (iUSE_RS3 && m_blocked(iRS3)) || (iISSUE_EN && m_blocked(iISSUE_RD));
   endfunction

   function automatic bit m_legal();
      return iCSR_ADDR == 12'h001 || iCSR_ADDR == 12'h002 || iCSR_ADDR == 12'h003;
   endfunction

   function automatic int m_csr_value();
      case (iCSR_ADDR)
         12'h001: return m_fflags;
         12'h002: return m_frm;
         12'h003: return m_frm * 32 + m_fflags;
         default: return 0;
      endcase
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 0;
      end
      m_frm = 0;
      m_fflags = 0;
   endtask

   task automatic idle();
      iRST = 0; iRS1 = 0; iRS2 = 0; iRS3 = 0;
      iUSE_RS1 = 0; iUSE_RS2 = 0; iUSE_RS3 = 0;
      iISSUE_EN = 0; iISSUE_RD = 0;
      iWR_EN = 0; iWR_ADDR = 0; iWR_DATA = 0; iWR_FLAGS = 0;
      iCSR_EN = 0; iCSR_OP = 0; iCSR_ADDR = 0; iCSR_WDATA = 0;
   endtask

   // check all outputs against the model, advance the model, and move to the next negedge
   task automatic cycle();
      bit s;
      int oldv, w, nv;
      #1;
      check("rs1_data", oRS1_DATA, m_read(iRS1));
      check("rs2_data", oRS2_DATA, m_read(iRS2));
      check("rs3_data", oRS3_DATA, m_read(iRS3));
      check("stall", {31'b0, oSTALL}, {31'b0, m_stall()});
      check("csr_rdata", oCSR_RDATA, (iCSR_EN && m_legal()) ? m_csr_value() : 0);
      check("csr_illegal", {31'b0, oCSR_ILLEGAL}, {31'b0, iCSR_EN && !m_legal()});
      check("frm", {29'b0, oFRM}, m_frm);
      check("frm_invalid", {31'b0, oFRM_INVALID}, (m_frm >= 5) ? 1 : 0);
      if (iRST) begin
         m_clear();
      end else begin
         s = m_stall();
         if (iCSR_EN && m_legal() && iCSR_OP != 2'b00) begin
            oldv = m_csr_value();
            w = int'(iCSR_WDATA[7:0]);
            case (iCSR_OP)
               2'b01:   nv = w;
               2'b10:   nv = oldv | w;
               default: nv = oldv & ~w;
            endcase
            nv = nv & 255;
            if (iCSR_ADDR == 12'h001) m_fflags = nv % 32;
            else if (iCSR_ADDR == 12'h002) m_frm = nv % 8;
            else begin
               m_frm = nv / 32;
               m_fflags = nv % 32;
            end
         end
         if (iWR_EN) begin
            m_regs[iWR_ADDR] = iWR_DATA;
            m_busy[iWR_ADDR] = 0;
            m_fflags = m_fflags | int'(iWR_FLAGS);
         end
         if (iISSUE_EN && !s) m_busy[iISSUE_RD] = 1;
      end
      @(posedge iCLK);
      @(negedge iCLK);
   endtask

   initial begin
      idle();
      iRST = 1;
      @(posedge iCLK);
      @(negedge iCLK);
      m_clear();
      idle();

      // reset state
      iRS1 = 0; iRS2 = 17; iRS3 = 31; iUSE_RS1 = 1; iUSE_RS2 = 1; iUSE_RS3 = 1;
      #1;
      check("rst_stall", {31'b0, oSTALL}, 0);
      check("rst_rs3", oRS3_DATA, 0);
      cycle();

      // write-through bypass then stored read
      idle(); iWR_EN = 1; iWR_ADDR = 5; iWR_DATA = 32'h3F800000; iRS1 = 5;
      #1; check("f5_bypass", oRS1_DATA, 32'h3F800000);
      cycle();
      idle(); iRS1 = 5;
      #1; check("f5_read", oRS1_DATA, 32'h3F800000);
      cycle();

      // RAW stall resolved by same-cycle writeback
      idle(); iISSUE_EN = 1; iISSUE_RD = 7; cycle();
      idle(); iUSE_RS2 = 1; iRS2 = 7;
      #1; check("raw_stall", {31'b0, oSTALL}, 1);
      cycle();
      iWR_EN = 1; iWR_ADDR = 7; iWR_DATA = 32'h12345678;
      #1; check("raw_wb_release", {31'b0, oSTALL}, 0);
      cycle();
      idle(); iUSE_RS2 = 1; iRS2 = 7;
      #1; check("busy7_cleared", {31'b0, oSTALL}, 0);
      cycle();

      // fflags accumulation and CSR clear merged with writeback flags
      idle(); iWR_EN = 1; iWR_ADDR = 1; iWR_FLAGS = 5'b00001; cycle();
      iWR_FLAGS = 5'b10000; cycle();
      idle(); iCSR_EN = 1; iCSR_ADDR = 12'h001;
      #1; check("fflags_acc", oCSR_RDATA, 32'h11);
      cycle();
      idle(); iCSR_EN = 1; iCSR_OP = 2'b11; iCSR_ADDR = 12'h001; iCSR_WDATA = 32'h1;
      iWR_EN = 1; iWR_ADDR = 2; iWR_FLAGS = 5'h04; cycle();
      idle(); iCSR_EN = 1; iCSR_ADDR = 12'h001;
      #1; check("fflags_clr_merge", oCSR_RDATA, 32'h14);
      cycle();

      // fcsr write with a reserved rounding mode
      idle(); iCSR_EN = 1; iCSR_OP = 2'b01; iCSR_ADDR = 12'h003; iCSR_WDATA = 32'hE5;
      #1; check("frm_no_bypass", {29'b0, oFRM}, 0);
      cycle();
      idle(); iCSR_EN = 1; iCSR_ADDR = 12'h002;
      #1;
      check("frm_7", {29'b0, oFRM}, 7);
      check("frm_invalid_7", {31'b0, oFRM_INVALID}, 1);
      check("frm_read", oCSR_RDATA, 32'h7);
      cycle();

      // illegal CSR address leaves fcsr alone
      idle(); iCSR_EN = 1; iCSR_OP = 2'b01; iCSR_ADDR = 12'h300; iCSR_WDATA = 32'hFF;
      #1;
      check("illegal_flag", {31'b0, oCSR_ILLEGAL}, 1);
      check("illegal_rdata", oCSR_RDATA, 0);
      cycle();
      idle(); iCSR_EN = 1; iCSR_ADDR = 12'h003;
      #1; check("fcsr_unchanged", oCSR_RDATA, 32'hE5);
      cycle();

      // reset while an operation is in flight
      idle(); iISSUE_EN = 1; iISSUE_RD = 3; cycle();
      idle(); iRST = 1; cycle();
      idle(); iUSE_RS1 = 1; iRS1 = 3; iRS2 = 5; iRS3 = 7;
      #1;
      check("rst_busy3", {31'b0, oSTALL}, 0);
      check("rst_f5", oRS2_DATA, 0);
      check("rst_f7", oRS3_DATA, 0);
      check("rst_frm", {29'b0, oFRM}, 0);
      cycle();
      idle(); iWR_EN = 1; iWR_ADDR = 3; iWR_DATA = 32'h40000000; cycle();
      idle(); iRS1 = 3;
      #1; check("late_wb_f3", oRS1_DATA, 32'h40000000);
      cycle();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         idle();
         iRST      = ($urandom_range(0, 127) == 0);
         iRS1      = 5'($urandom_range(0, 7));
         iRS2      = 5'($urandom_range(0, 31));
         iRS3      = 5'($urandom_range(0, 7));
         iUSE_RS1  = 1'($urandom);
         iUSE_RS2  = 1'($urandom);
         iUSE_RS3  = 1'($urandom);
         iISSUE_EN = ($urandom_range(0, 2) == 0);
         iISSUE_RD = 5'($urandom_range(0, 7));
         iWR_EN    = 1'($urandom);
         iWR_ADDR  = 5'($urandom_range(0, 7));
         iWR_DATA  = $urandom;
         iWR_FLAGS = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
         iCSR_EN   = ($urandom_range(0, 3) == 0);
         iCSR_OP   = 2'($urandom);
         case ($urandom_range(0, 5))
            0: iCSR_ADDR = 12'h001;
            1: iCSR_ADDR = 12'h002;
            2: iCSR_ADDR = 12'h003;
            3: iCSR_ADDR = 12'h000;
            4: iCSR_ADDR = 12'h300;
            default: iCSR_ADDR = 12'($urandom);
         endcase
         iCSR_WDATA = $urandom;
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/rv32f_fpr_file.md
RV32F_FPR_FILE -- requirements
Module: rv32f_fpr_file

Interface
REQ-001 Parameter: NREG, 32, number of floating-point registers (f0..f31).
REQ-002 Parameter: FLEN, 32, register width in bits.
REQ-003 Port: iCLK  in  1  single clock; all state updates on rising edge.
REQ-004 Port: iRST  in  1  reset; synchronous, active-high.
REQ-005 Ports: iRS1, iRS2, iRS3  in  5 each  source register indices.
REQ-006 Ports: oRS1_DATA, oRS2_DATA, oRS3_DATA  out  32 each  source operands for the FP execute stage.
REQ-007 Ports: iUSE_RS1, iUSE_RS2, iUSE_RS3  in  1 each  source is actually read by the issuing instruction.
REQ-008 Ports: iISSUE_EN  in  1, iISSUE_RD  in  5  an FP instruction targeting rd issues this cycle.
REQ-009 Ports: iWR_EN  in  1, iWR_ADDR  in  5, iWR_DATA  in  32, iWR_FLAGS  in  5  writeback from execute; flags are {NV,DZ,OF,UF,NX}.
REQ-010 Ports: iCSR_EN  in  1, iCSR_OP  in  2, iCSR_ADDR  in  12, iCSR_WDATA  in  32  CSR access; op 01 write, 10 set, 11 clear, 00 read-only.
REQ-011 Ports: oCSR_RDATA  out  32, oCSR_ILLEGAL  out  1  CSR read value and bad-address flag.
REQ-012 Ports: oFRM  out  3, oFRM_INVALID  out  1, oSTALL  out  1  dynamic rounding mode, reserved-mode flag, issue stall.

Function
REQ-013 Reads SHALL be combinational; f0 SHALL be an ordinary writable register (not hardwired zero).
REQ-014 A read whose index equals iWR_ADDR while iWR_EN=1 SHALL return iWR_DATA (write-through bypass); otherwise the stored value.
REQ-015 iWR_EN=1 SHALL store iWR_DATA into register iWR_ADDR at the next edge.
REQ-016 Scoreboard: busy[iISSUE_RD] SHALL be set on iISSUE_EN; busy[iWR_ADDR] SHALL be cleared on iWR_EN; on the same index in the same cycle, set SHALL win.
REQ-017 oSTALL SHALL be 1 when any source with iUSE_RSn=1 is busy and is not the register written back this cycle, or when iISSUE_EN=1 and busy[iISSUE_RD]=1 and it is not being written back (WAW).
REQ-018 While oSTALL=1 the scoreboard SHALL ignore iISSUE_EN (no busy bit set).
REQ-019 fcsr SHALL hold frm[2:0] and fflags[4:0]; CSR addresses 0x001 fflags, 0x002 frm, 0x003 fcsr ({frm,fflags} in bits 7:0).
REQ-020 oCSR_RDATA SHALL be the pre-update value, zero-extended, whenever iCSR_EN=1 with a legal address; 0 otherwise.
REQ-021 A CSR op SHALL update only the addressed fields: write = wdata, set = old|wdata, clear = old&~wdata, using the low 5/3/8 bits.
REQ-022 Any other address with iCSR_EN=1 SHALL assert oCSR_ILLEGAL combinationally and change no state.
REQ-023 On iWR_EN=1, fflags SHALL accumulate iWR_FLAGS by OR; when a CSR op updates fflags in the same cycle, the result SHALL be (CSR result) | iWR_FLAGS.
REQ-024 frm SHALL store any written value; oFRM_INVALID SHALL be 1 when frm is 5, 6 or 7.
REQ-025 oFRM SHALL reflect the stored frm (no bypass of a same-cycle CSR write).

Reset
REQ-026 With iRST=1 at an edge: all registers, busy bits, frm and fflags SHALL become 0; writes, issues and CSR ops in that cycle SHALL be discarded.
REQ-027 After reset: oSTALL=0, oFRM=0, oFRM_INVALID=0, oCSR_ILLEGAL=0 (iCSR_EN=0), and all read data = 0.
REQ-028 Reset during an in-flight long-latency operation SHALL clear its busy bit; a later writeback SHALL still be written normally.

Structure
REQ-029 Package rv32f_pkg SHALL hold the CSR addresses, CSR op encodings, fflags bit positions and the frm reserved values.
REQ-030 The scoreboard (busy vector, stall logic) SHALL be a sub-module rv32f_scoreboard; the register array and fcsr stay in the top level.

Verification
REQ-031 Write f5=0x3F800000, then read rs1=5 next cycle -> 0x3F800000; same-cycle read with iWR_EN -> 0x3F800000 via bypass.
REQ-032 Issue rd=7; next cycle iUSE_RS2=1, iRS2=7 -> oSTALL=1; writeback f7 in the same cycle -> oSTALL=0, busy[7] cleared.
REQ-033 Writeback flags 5'b00001, then 5'b10000 -> read 0x001 returns 0x11; CSR clear 0x01 together with writeback flags 0x04 -> fflags=0x14.
REQ-034 CSR write 0x003 with 0xE5 -> frm=7, fflags=0x05, oFRM_INVALID=1; read 0x002 -> 0x7.
REQ-035 CSR access to 0x300 -> oCSR_ILLEGAL=1, oCSR_RDATA=0, fcsr unchanged.
REQ-036 Issue rd=3, assert iRST for one cycle -> oSTALL=0 for a source of 3, all reads 0; a following writeback of f3=0x40000000 is stored.
